fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `asyncfifo` write port among `NUM_REQ` requesters in the write clock domain. Each requester presents bursts over a valid/ready handshake. The arbiter locks onto one requester per burst and forwards its beats to `wpush`/`wdata`. It never pushes while `wfull` is high and never interleaves beats of different bursts. It sits directly in front of the `asyncfifo` write side, e.g. where several core-side sources feed one clock-crossing queue.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `DATA_WIDTH`, default 32: beat width; must match the FIFO's `DATA_WIDTH`.
- `MAX_BURST`, default 4: maximum beats per grant; legal range ≥1.

Ports:
- `clk` input 1: write-domain clock, i.e. the FIFO's `wclk`.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NUM_REQ: bit i set means requester i has a beat.
- `req_data` input NUM_REQ*DATA_WIDTH: requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last` input NUM_REQ: bit i marks requester i's current beat as the end of its burst.
- `req_ready` output NUM_REQ: one-hot or zero; bit i means requester i's beat is accepted this cycle.
- `wpush` output 1: to FIFO `wpush`.
- `wdata` output DATA_WIDTH: to FIFO `wdata`.
- `wfull` input 1: from FIFO `wfull`.
- `grant_id` output clog2(NUM_REQ): current or last granted requester.
- `busy` output 1: high while in LOCK.

## Operation
- State registers:
  - FSM state: IDLE or LOCK.
  - `grant_id`.
  - `rr_ptr`, clog2(NUM_REQ) bits.
  - `beat_cnt`, clog2(MAX_BURST)+1 bits.
- **IDLE**
  - If any `req_valid` bit is set, select the first requester with valid set, scanning from `rr_ptr` upward and wrapping modulo NUM_REQ.
  - Load that index into `grant_id`, clear `beat_cnt`, and go to LOCK.
  - No transfer happens in IDLE.
- **LOCK**
  - `accept = req_valid[grant_id] & ~wfull`.
  - `req_ready[grant_id] = ~wfull`. All other `req_ready` bits are 0.
  - `wpush = accept`, combinational.
  - `wdata = req_data[grant_id]`. The value is don't-care when `wpush` is 0; the bench must only check it when `wpush` is 1.
  - On `accept`, `beat_cnt` increments.
  - The burst ends on an accepted beat where `req_last[grant_id]` = 1 or `beat_cnt` = MAX_BURST-1. At burst end:
    - go to IDLE;
    - set `rr_ptr` = (`grant_id`+1) mod NUM_REQ, with wrap when NUM_REQ is not a power of two.
- **No preemption.** If the granted requester drops `req_valid` mid-burst, the grant is held until it resumes and completes. Requesters must not abandon bursts.
- **`wfull` high in LOCK.** `wpush` and all `req_ready` bits are 0. The requester holds its data, and no beat is lost or duplicated.
- **MAX_BURST cap.** The cap ends the grant without `req_last`. The requester's remaining beats form a new burst on its next grant.
- **Invariant:** `wpush` is never 1 while `wfull` is 1.

## Timing
- **Reset values** (applied immediately on `rst_n` low, no clock edge needed):
  - state = IDLE, `grant_id` = 0, `rr_ptr` = 0, `beat_cnt` = 0;
  - `busy` = 0, `req_ready` = 0, `wpush` = 0.
- **Reset mid-burst:** the burst is abandoned. The FIFO keeps the beats already pushed. After release, arbitration restarts from requester 0.
- **Latency:**
  - `req_valid` rising in IDLE leads to the first `wpush` on the next cycle (1-cycle arbitration).
  - Each accepted beat is pushed in the same cycle it is accepted (0 latency).
- **Throughput:** one beat per cycle inside a burst, plus one IDLE bubble between grants. Peak efficiency is MAX_BURST/(MAX_BURST+1).
- **`wfull` response:** `wfull` is sampled combinationally. A rise takes effect in the same cycle, giving at most zero overshoot.
- **Simultaneous events:**
  - burst end together with other requesters valid: the next grant is decided in the following IDLE cycle using the updated `rr_ptr`;
  - `req_last` together with `wfull`: no accept, so the burst does not end.

## Test plan
- **Single burst.** Req0 sends beats 2, 3, 4 with `req_last` on 4, `wfull`=0.
  - Required: `wpush` high for 3 consecutive cycles starting 1 cycle after valid, `wdata` 2, 3, 4, `grant_id`=0.
  - Then `busy` falls and `rr_ptr`=1.
- **Fairness.** All 4 requesters continuously valid with 1-beat bursts (`req_last`=1); requester i sends data 10+i.
  - Required: `wdata` sequence 10, 11, 12, 13, 10, …, each push separated by exactly one idle cycle.
- **Burst cap.** Req1 streams 6 beats (20..25) with no `req_last`; req2 is valid with 30.
  - Required pushes: 20, 21, 22, 23, then 30, then 24, 25.
- **Backpressure.** `wfull` held high for 3 cycles mid-burst.
  - Required during those cycles: `wpush`=0 and `req_ready`=0.
  - Required overall: every beat pushed exactly once, in order; the assertion `!(wpush && wfull)` holds throughout.
- **Async reset.** `rst_n` pulled low mid-burst between clock edges.
  - Required: `wpush`, `req_ready` and `busy` go to 0 before the next edge.
  - After release with req3 and req0 both valid, req0 is granted first.
- **End-to-end.** Arbiter driving `asyncfifo` (DATA_WIDTH 32, ADDR_WIDTH 4; wclk 20 ps, rclk 10 ps). Three requesters push 8 tagged words each; the reader pulls whenever `rempty` is 0.
  - Required: all 24 words received, and per-requester order is preserved.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async FIFO write port among NUM_REQ burst requesters.
// Latency: one IDLE arbitration cycle per grant, then one beat per cycle pushed in the cycle it is accepted.
// Backpressure: wfull combinationally drops wpush and req_ready; the granted requester holds its beat.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wpush,
  output logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          wfull,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
  localparam logic [BCW-1:0] CAP_CNT = BCW'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [IDW-1:0]        grant_nxt;
  logic [IDW-1:0]        rr_ptr, rr_nxt;
  logic [IDW-1:0]        pick_id;
  logic                  pick_vld;
  logic [BCW-1:0]        beat_cnt, beat_nxt;
  logic                  accept;
  logic                  burst_end;
  logic [DATA_WIDTH-1:0] req_dat_arr [NUM_REQ];

  // Modulo-NUM_REQ add that also works when NUM_REQ is not a power of two.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Split the flat data bus into one lane per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign req_dat_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: lowest offset from rr_ptr with valid set wins (descending scan, last hit kept).
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_ptr, k)]) begin
        pick_vld = 1'b1;
        pick_id  = wrap_add(rr_ptr, k);
      end
    end
  end

  // Next-state and outputs; a burst only ends on an accepted beat, so last-with-wfull keeps the lock.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    rr_nxt    = rr_ptr;
    beat_nxt  = beat_cnt;
    req_ready = '0;
    wpush     = 1'b0;
    accept    = 1'b0;
    burst_end = 1'b0;
    busy      = (state == LOCK);
    wdata     = req_dat_arr[grant_id];
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick_id;
          beat_nxt  = '0;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        req_ready[grant_id] = ~wfull;
        accept    = req_valid[grant_id] & ~wfull;
        wpush     = accept;
        burst_end = accept & (req_last[grant_id] | (beat_cnt == CAP_CNT));
        if (accept) beat_nxt = beat_cnt + 1'b1;
        if (burst_end) begin
          state_nxt = IDLE;
          rr_nxt    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any burst in flight and restarts arbitration at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= beat_nxt;
    end
  end

endmodule
